// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/div scheduler with HI/LO registers.
// Computes at issue, then holds a fixed busy window before committing.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_d
);

  localparam logic [4:0] MC = 5'(MULT_CYCLES);
  localparam logic [4:0] DC = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        bz_q, bz_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] sa64, sb64;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] ub_safe, sb_safe;
  logic [31:0] uq, ur, mq, mr, sq, sr;
  logic [63:0] res;

  assign sa64   = $signed({{32{a[31]}}, a});
  assign sb64   = $signed({{32{b[31]}}, b});
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    a_neg   = a[31];
    b_neg   = b[31];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    ub_safe = (b == 32'd0) ? 32'd1 : b;
    sb_safe = (b == 32'd0) ? 32'd1 : b_mag;
    uq      = a / ub_safe;
    ur      = a % ub_safe;
    mq      = a_mag / sb_safe;
    mr      = a_mag % sb_safe;
    sq      = (a_neg ^ b_neg) ? -mq : mq;
    sr      = a_neg ? -mr : mr;
  end

  always_comb begin
    res = 64'd0;
    unique case (md_op)
      2'b00: res = prod_s;
      2'b01: res = prod_u;
      2'b10: res = {sr, sq};
      2'b11: res = {ur, uq};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    bz_d    = bz_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = md_op[1] ? DC : MC;
          op_d    = md_op;
          bz_d    = (b == 32'd0);
          phi_d   = res[63:32];
          plo_d   = res[31:0];
        end else if (mt_we) begin
          if (mt_sel) lo_d = a;
          else        hi_d = a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          // A divide by zero burns its window but leaves HI/LO alone.
          if (!((op_q inside {2'b10, 2'b11}) && bz_q)) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      bz_q    <= 1'b0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      bz_q    <= bz_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q == RUN);
  assign stall_d = d_uses_md & (busy | start);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized scoreboard bench for md_sched.
// Reference results come from 64-bit integer arithmetic.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic        mt_we;
  logic        mt_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_d;

  md_sched #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .mt_we    (mt_we),
    .mt_sel   (mt_sel),
    .a        (a),
    .b        (b),
    .d_uses_md(d_uses_md),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall_d  (stall_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {hi, lo}; divisor must be nonzero for divides.
  function automatic logic [63:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      2'b00: begin q = sx * sy; return q; end
      2'b01: begin p = ux * uy; return p; end
      2'b10: begin
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Monitor: every falling edge of busy is a commit to score.
  initial begin : mon
    bit   pb;
    int   cnt;
    exp_t e;
    pb  = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pb  = 1'b0;
        cnt = 0;
      end else begin
        if (busy) cnt++;
        else if (pb) begin
          chk("commit_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("commit_hi", 64'(hi), 64'(e.h));
            chk("commit_lo", 64'(lo), 64'(e.l));
            chk("busy_len", 64'(cnt), 64'(e.n));
          end
          cnt = 0;
        end
        pb = busy;
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit with_mt,
                       input bit mt_run, input bit tail);
    int          n;
    logic [63:0] r;
    exp_t        e;
    n = op[1] ? DIV_N : MULT_N;
    start     = 1'b1;
    md_op     = op;
    a         = x;
    b         = y;
    mt_we     = with_mt;
    mt_sel    = 1'b1;
    d_uses_md = 1'($urandom_range(0, 1));
    if (op[1] && y == 32'd0) r = {ref_hi, ref_lo};
    else                     r = ref_res(op, x, y);
    ref_hi = r[63:32];
    ref_lo = r[31:0];
    e.h = ref_hi;
    e.l = ref_lo;
    e.n = n;
    sb.push_back(e);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      chk("stall_win", 64'(stall_d), 64'(d_uses_md));
      chk("busy_win", 64'(busy), 64'(k >= 1));
      @(posedge clk);
      #1;
      start     = 1'b0;
      mt_we     = mt_run && (k == 1);
      mt_sel    = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      d_uses_md = 1'($urandom_range(0, 1));
    end
    mt_we = 1'b0;
    if (tail) begin
      d_uses_md = 1'b1;
      @(negedge clk);
      chk("stall_after", 64'(stall_d), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mtw(input bit sel, input logic [31:0] v);
    mt_we  = 1'b1;
    mt_sel = sel;
    a      = v;
    @(posedge clk);
    #1;
    mt_we = 1'b0;
    if (sel) ref_lo = v;
    else     ref_hi = v;
    @(negedge clk);
    chk("mt_hi", 64'(hi), 64'(ref_hi));
    chk("mt_lo", 64'(lo), 64'(ref_lo));
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0] x, y;
    logic [1:0]  op;
    reset     = 1'b0;
    start     = 1'b1;
    md_op     = 2'b00;
    mt_we     = 1'b0;
    mt_sel    = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    d_uses_md = 1'b1;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall_start", 64'(stall_d), 64'd1);
    start = 1'b0;
    #1;
    chk("rst_stall_nostart", 64'(stall_d), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    issue(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b1);
    chk("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    issue(2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b1);
    chk("multu_hi", 64'(hi), 64'd2);
    chk("multu_lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b1);
    chk("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    issue(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, 1'b1);
    chk("divu_hi", 64'(hi), 64'd1);
    chk("divu_lo", 64'(lo), 64'd3);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    chk("divmin_hi", 64'(hi), 64'd0);
    chk("divmin_lo", 64'(lo), 64'h0000_0000_8000_0000);

    mtw(1'b0, 32'h12345678);
    issue(2'b10, 32'd99, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("div0_hi", 64'(hi), 64'h0000_0000_1234_5678);
    chk("div0_lo", 64'(lo), 64'h0000_0000_8000_0000);

    issue(2'b01, 32'hAAAA0000, 32'd3, 1'b1, 1'b0, 1'b1);
    chk("start_mt_lo", 64'(lo), 64'h0000_0000_FFFE_0000);
    issue(2'b00, 32'd1234, 32'd5678, 1'b0, 1'b1, 1'b1);

    // Abort a divide two cycles into its window.
    start = 1'b1;
    md_op = 2'b11;
    a     = 32'd1000;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    sb.delete();
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("abort_nocommit_hi", 64'(hi), 64'd0);
    chk("abort_nocommit_lo", 64'(lo), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    issue(2'b00, 32'd6, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b1);
    chk("post_abort_lo", 64'(lo), 64'h0000_0000_FFFF_FFD6);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mtw(1'($urandom_range(0, 1)), $urandom);
      end else begin
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       x = ref_lo;
          1:       x = 32'($urandom_range(0, 100));
          default: x = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0:       y = 32'd0;
          1:       y = 32'hFFFFFFFF;
          2, 3:    y = 32'($urandom_range(1, 50));
          default: y = $urandom;
        endcase
        issue(op, x, y, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_hi", 64'(hi), 64'(ref_hi));
    chk("final_lo", 64'(lo), 64'(ref_lo));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
